// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side operand/stage info in, forwarding selects and stall controls out.
// Port names follow the pipeline's existing signal names.
interface hazard_ctrl_if #(
  parameter int REGW = 5,
  parameter int NSRC = 2,
  parameter int NFWD = 2,
  parameter int CNTW = 32,
  parameter int SELW = $clog2(NFWD + 1)
);
  logic                 id_valid;
  logic [NSRC*REGW-1:0] id_rs;
  logic [NSRC*REGW-1:0] ex_rs;
  logic [REGW-1:0]      ex_rd;
  logic                 ex_wb;
  logic                 ex_is_load;
  logic [NFWD*REGW-1:0] stg_rd;
  logic [NFWD-1:0]      stg_wb;
  logic [NFWD-1:0]      stg_ok;
  logic                 mem_busy;
  logic                 flush;

  logic [NSRC*SELW-1:0] fwd_sel;
  logic [NSRC-1:0]      fwd_notready;
  logic                 pc_hold;
  logic                 ifid_hold;
  logic                 idex_bubble;
  logic                 pipe_freeze;
  logic [CNTW-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs, ex_rs, ex_rd, ex_wb, ex_is_load,
           stg_rd, stg_wb, stg_ok, mem_busy, flush,
    input  fwd_sel, fwd_notready, pc_hold, ifid_hold, idex_bubble,
           pipe_freeze, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, ex_rs, ex_rd, ex_wb, ex_is_load,
           stg_rd, stg_wb, stg_ok, mem_busy, flush,
    output fwd_sel, fwd_notready, pc_hold, ifid_hold, idex_bubble,
           pipe_freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Operand forwarding select and load-use stall sequencing for the in-order pipeline.
//   state  | meaning
//   RUN    | no stall in progress; stall outputs follow the live load-use detect
//   LSTALL | extra load-use stall cycles pending, count held in rem
module hazard_ctrl #(
  parameter int REGW     = 5,
  parameter int NSRC     = 2,
  parameter int NFWD     = 2,
  parameter int LOAD_STG = 2,
  parameter int CNTW     = 32,
  parameter int SELW     = $clog2(NFWD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int REMW = (LOAD_STG > 2) ? $clog2(LOAD_STG - 1) : 1;

  typedef enum logic {
    RUN,
    LSTALL
  } stateT;

  stateT                state;
  stateT                stateNxt;
  logic [REMW-1:0]      rem;
  logic [REMW-1:0]      remNxt;
  logic [CNTW-1:0]      stallCnt;
  logic                 stallOut;
  logic                 srcHit;
  logic                 hz;
  logic [NSRC*SELW-1:0] fwdSel;
  logic [NSRC-1:0]      fwdNotReady;

  // Scan oldest to youngest so the nearest matching stage is the last one written,
  // even when that stage is not ready yet.
  always_comb begin
    fwdSel      = '0;
    fwdNotReady = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NFWD; k >= 1; k--) begin
        if (bus.stg_wb[k-1] &&
            (bus.stg_rd[(k-1)*REGW +: REGW] == bus.ex_rs[i*REGW +: REGW]) &&
            (bus.ex_rs[i*REGW +: REGW] != '0)) begin
          fwdSel[i*SELW +: SELW] = SELW'(k);
          fwdNotReady[i]         = ~bus.stg_ok[k-1];
        end
      end
    end
  end

  always_comb begin
    srcHit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.id_rs[i*REGW +: REGW] == bus.ex_rd) srcHit = 1'b1;
    end
  end

  assign hz = bus.id_valid & bus.ex_wb & bus.ex_is_load & (bus.ex_rd != '0) &
              srcHit & ~bus.flush;

  always_comb begin
    stateNxt = state;
    remNxt   = rem;
    stallOut = 1'b0;
    case (state)
      RUN: begin
        stallOut = hz;
        if (hz && (LOAD_STG > 2)) begin
          stateNxt = LSTALL;
          remNxt   = REMW'(LOAD_STG - 2);
        end
      end
      LSTALL: begin
        stallOut = ~bus.flush;
        if (bus.flush || (rem == REMW'(1))) begin
          stateNxt = RUN;
          remNxt   = '0;
        end else begin
          remNxt = rem - REMW'(1);
        end
      end
      default: begin
        stateNxt = RUN;
        remNxt   = '0;
      end
    endcase
  end

  // A busy memory freezes every register here, so the next-state logic needs no busy term.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      rem      <= '0;
      stallCnt <= '0;
    end else if (!bus.mem_busy) begin
      state <= stateNxt;
      rem   <= remNxt;
      if (stallOut && (stallCnt != '1)) stallCnt <= stallCnt + CNTW'(1);
    end
  end

  assign bus.fwd_sel      = fwdSel;
  assign bus.fwd_notready = fwdNotReady;
  assign bus.pc_hold      = stallOut;
  assign bus.ifid_hold    = stallOut;
  assign bus.idex_bubble  = stallOut;
  assign bus.pipe_freeze  = bus.mem_busy;
  assign bus.stall_cnt    = stallCnt;

endmodule
